cdb_rr_arbiter: RTL

//  Parametrised common-data-bus arbiter, successor to the fixed 2-wide CDB. Collects completions
//  (tag + result + ROB index) from FU_NUM functional units via valid/ready handshakes, buffers one
//  per FU, grants up to CDB_WIDTH per cycle in round-robin order and drives registered CDB lanes
//  to RS wakeup, PRF write and ROB complete. Adds fairness, backpressure and branch-flush squash.

---
 rtl/cdb_pkg.sv | 36 +++
 rtl/cdb_rr_arbiter_rr_multi_grant.sv | 53 +++++
 rtl/cdb_rr_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter: default
// configuration values, the broadcast packet/lane types and small index
// helpers used by the round-robin grant logic.
package cdb_pkg;

    localparam int DEF_FU_NUM    = 8;
    localparam int DEF_CDB_WIDTH = 2;
    localparam int DEF_PREG_NUM  = 64;
    localparam int DEF_ROB_NUM   = 32;
    localparam int DEF_DATA_W    = 32;

    localparam int PKT_TAG_W = $clog2(DEF_PREG_NUM);
    localparam int PKT_ROB_W = $clog2(DEF_ROB_NUM);

    typedef struct packed {
        logic [PKT_TAG_W-1:0]  tag;
        logic [PKT_ROB_W-1:0]  rob;
        logic [DEF_DATA_W-1:0] data;
    } cdb_pkt_t;

    typedef struct packed {
        logic     valid;
        cdb_pkt_t pkt;
    } cdb_lane_t;

    // Index width for a ring of n entries; a one-entry ring still needs a bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Successor of idx on a ring of n entries.
    function automatic int ringNext(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_rr_arbiter_rr_multi_grant.sv
// Combinational multi-grant round-robin selector. Walks the request
// vector starting at ptr_i and grants the first CDB_WIDTH requesters,
// reporting which source feeds each lane and where the pointer moves.
module rr_multi_grant
    import cdb_pkg::*;
#(
    parameter int FU_NUM    = DEF_FU_NUM,
    parameter int CDB_WIDTH = DEF_CDB_WIDTH,
    localparam int IW       = idxWidth(FU_NUM)
) (
    input  logic [FU_NUM-1:0]       req_i,
    input  logic [IW-1:0]           ptr_i,
    output logic [FU_NUM-1:0]       gnt_o,
    output logic [CDB_WIDTH*IW-1:0] laneIdx_o,
    output logic [CDB_WIDTH-1:0]    laneValid_o,
    output logic [IW-1:0]           nextPtr_o
);

    int            idx;
    int            count;
    logic [IW-1:0] idxSel;

    // Scan the ring from the pointer; each hit takes the next free lane and
    // drags the pointer to just past itself, so the last grant sets it.
    always_comb begin
        gnt_o       = '0;
        laneIdx_o   = '0;
        laneValid_o = '0;
        nextPtr_o   = ptr_i;
        count       = 0;
        idx         = 0;
        idxSel      = '0;
        for (int off = 0; off < FU_NUM; off++) begin
            idx = int'(ptr_i) + off;
            if (idx >= FU_NUM) begin
                idx = idx - FU_NUM;
            end
            idxSel = IW'(idx);
            if (req_i[idxSel] && (count < CDB_WIDTH)) begin
                gnt_o[idxSel] = 1'b1;
                for (int k = 0; k < CDB_WIDTH; k++) begin
                    if (count == k) begin
                        laneIdx_o[k*IW +: IW] = idxSel;
                        laneValid_o[k]        = 1'b1;
                    end
                end
                nextPtr_o = IW'(ringNext(idx, FU_NUM));
                count     = count + 1;
            end
        end
    end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Common-data-bus arbiter. Each functional unit hands its completion
// into a one-deep hold slot; up to CDB_WIDTH held completions per cycle
// are chosen round-robin and driven onto registered broadcast lanes.
// A branch flush empties every slot and silences the next bus cycle.
module cdb_rr_arbiter
    import cdb_pkg::*;
#(
    parameter int FU_NUM    = DEF_FU_NUM,
    parameter int CDB_WIDTH = DEF_CDB_WIDTH,
    parameter int PREG_NUM  = DEF_PREG_NUM,
    parameter int ROB_NUM   = DEF_ROB_NUM,
    parameter int DATA_W    = DEF_DATA_W,
    localparam int PT       = $clog2(PREG_NUM),
    localparam int RT       = $clog2(ROB_NUM),
    localparam int IW       = idxWidth(FU_NUM)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush_i,
    input  logic [FU_NUM-1:0]           fu_valid_i,
    input  logic [FU_NUM*PT-1:0]        fu_tag_i,
    input  logic [FU_NUM*RT-1:0]        fu_rob_i,
    input  logic [FU_NUM*DATA_W-1:0]    fu_data_i,
    output logic [FU_NUM-1:0]           fu_ready_o,
    output logic [CDB_WIDTH-1:0]        cdb_valid_o,
    output logic [CDB_WIDTH*PT-1:0]     cdb_tag_o,
    output logic [CDB_WIDTH*RT-1:0]     cdb_rob_o,
    output logic [CDB_WIDTH*DATA_W-1:0] cdb_data_o
);

    typedef struct packed {
        logic [PT-1:0]     tag;
        logic [RT-1:0]     rob;
        logic [DATA_W-1:0] data;
    } pkt_t;

    logic [FU_NUM-1:0]       holdValid_q;
    logic [FU_NUM-1:0]       holdValid_d;
    pkt_t                    hold_q [FU_NUM];
    pkt_t                    hold_d [FU_NUM];
    logic [IW-1:0]           ptr_q;
    logic [IW-1:0]           ptr_d;
    logic [CDB_WIDTH-1:0]    laneValid_q;
    logic [CDB_WIDTH-1:0]    laneValid_d;
    pkt_t                    lanePkt_q [CDB_WIDTH];
    pkt_t                    lanePkt_d [CDB_WIDTH];

    logic [FU_NUM-1:0]       gnt;
    logic [CDB_WIDTH*IW-1:0] laneIdx;
    logic [CDB_WIDTH-1:0]    laneSel;
    logic [IW-1:0]           nextPtr;
    logic [FU_NUM-1:0]       handshake;
    logic [IW-1:0]           laneSrc;

    // Grant looks only at the hold slots, so the ready path never loops
    // back through fu_valid_i.
    rr_multi_grant #(
        .FU_NUM    (FU_NUM),
        .CDB_WIDTH (CDB_WIDTH)
    ) u_grant (
        .req_i       (holdValid_q),
        .ptr_i       (ptr_q),
        .gnt_o       (gnt),
        .laneIdx_o   (laneIdx),
        .laneValid_o (laneSel),
        .nextPtr_o   (nextPtr)
    );

    // A slot can take a new completion when empty or when it is being
    // drained this cycle; nothing is accepted while a flush is squashing.
    always_comb begin
        fu_ready_o = '0;
        for (int i = 0; i < FU_NUM; i++) begin
            fu_ready_o[i] = ~flush_i & (~holdValid_q[i] | gnt[i]);
        end
    end

    // Hold slot next state: a fresh handshake wins over a same-cycle drain,
    // a drain or flush empties the slot, and the payload stays put otherwise.
    always_comb begin
        holdValid_d = holdValid_q;
        handshake   = '0;
        for (int i = 0; i < FU_NUM; i++) begin
            hold_d[i]    = hold_q[i];
            handshake[i] = fu_valid_i[i] & fu_ready_o[i];
            if (handshake[i]) begin
                holdValid_d[i]  = 1'b1;
                hold_d[i].tag   = fu_tag_i[i*PT +: PT];
                hold_d[i].rob   = fu_rob_i[i*RT +: RT];
                hold_d[i].data  = fu_data_i[i*DATA_W +: DATA_W];
            end else if (flush_i || gnt[i]) begin
                holdValid_d[i] = 1'b0;
            end
        end
    end

    // Lane and pointer next state: granted slots feed lanes in scan order,
    // idle lanes carry zeros, and a flush blanks the bus without moving
    // the pointer.
    always_comb begin
        laneSrc = '0;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            laneValid_d[k] = laneSel[k] & ~flush_i;
            lanePkt_d[k]   = '0;
            laneSrc        = laneIdx[k*IW +: IW];
            if (laneValid_d[k]) begin
                lanePkt_d[k] = hold_q[laneSrc];
            end
        end
        ptr_d = flush_i ? ptr_q : nextPtr;
    end

    // State registers; reset clears everything and overrides flush and
    // any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            holdValid_q <= '0;
            ptr_q       <= '0;
            laneValid_q <= '0;
            for (int i = 0; i < FU_NUM; i++) begin
                hold_q[i] <= '0;
            end
            for (int k = 0; k < CDB_WIDTH; k++) begin
                lanePkt_q[k] <= '0;
            end
        end else begin
            holdValid_q <= holdValid_d;
            ptr_q       <= ptr_d;
            laneValid_q <= laneValid_d;
            for (int i = 0; i < FU_NUM; i++) begin
                hold_q[i] <= hold_d[i];
            end
            for (int k = 0; k < CDB_WIDTH; k++) begin
                lanePkt_q[k] <= lanePkt_d[k];
            end
        end
    end

    // Flatten the registered lanes onto the broadcast ports.
    always_comb begin
        cdb_valid_o = laneValid_q;
        cdb_tag_o   = '0;
        cdb_rob_o   = '0;
        cdb_data_o  = '0;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            cdb_tag_o[k*PT +: PT]          = lanePkt_q[k].tag;
            cdb_rob_o[k*RT +: RT]          = lanePkt_q[k].rob;
            cdb_data_o[k*DATA_W +: DATA_W] = lanePkt_q[k].data;
        end
    end

endmodule
